fx3_mem_bridge: RTL and testbench
=================================

// Module: fx3_mem_bridge
// PURPOSE
//  Single-clock bridge between an FX3-style 32-bit slave-FIFO (GPIF-II) port and an on-chip word memory.
//  Acts as FIFO master: pops command packets from the USB-to-FPGA thread, executes memory writes/reads,
//  and pushes responses to the FPGA-to-USB thread. Sits under the board top, beside the clock manager.
// PARAMETERS
//  PCLK_INV    1'b1         1: SL_PCLK=~SYS_CLK; 0: SL_PCLK=SYS_CLK
//  PCLK_FREQ   80_000_000   SYS_CLK/SL_PCLK frequency in Hz, informational only
//  FPGA_FAMILY "ARTIX7"     informational only, no functional effect
//  MEM_SIZE    8192         memory size in bytes, power of two, >=16; MEM_SIZE/4 words of 32 bits
// PORTS
//  SYS_CLK        in   1   sole clock, all logic on posedge
//  SYS_RST        in   1   reset, asynchronous, active-high
//  SYS_CLK_STABLE in   1   clock-manager lock; 0 holds the block in reset
//  SYS_RST_N      out  1   internal reset status, 1 = running
//  SL_RST_N       in   1   host reset, active-low
//  SL_PCLK        out  1   slave-FIFO clock
//  SL_CS_N        out  1   chip select, active-low
//  SL_RD_N SL_WR_N SL_OE_N SL_PKTEND_N  out 1 each  FIFO strobes, active-low
//  SL_AD          out  2   thread address: 2'b00 = U2F (host->FPGA), 2'b11 = F2U (FPGA->host)
//  SL_FLAGA       in   1   1 = U2F thread has data
//  SL_FLAGB       in   1   1 = F2U thread has space
//  SL_FLAGC SL_FLAGD in 1 each  unused, ignored
//  SL_DT          inout 32 FIFO data bus
//  SL_MODE        in   2   2'b00 = run; other values keep FSM in IDLE
// BEHAVIOUR
//  Reset:
//   - rst = SYS_RST | ~SL_RST_N | ~SYS_CLK_STABLE; asserts asynchronously, deasserts via 2-flop sync.
//   - SYS_RST_N = ~rst (synchronized).
//  Output values while rst:
//   - SL_CS_N=SL_RD_N=SL_WR_N=SL_OE_N=SL_PKTEND_N=1; SL_AD=2'b00; SL_DT hi-Z; FSM=IDLE.
//   - Memory contents not cleared.
//  Clock: SL_PCLK = PCLK_INV ? ~SYS_CLK : SYS_CLK, combinational, also during reset.
//  Packet format (all words from U2F):
//   - W0 header: [31] 1=write/0=read; [30:16] ignored; [15:0] LEN in words, 1..256.
//   - W1 byte address: bits [1:0] ignored.
//   - Write only: LEN payload words follow.
//  Word addressing: index = addr[log2(MEM_SIZE)-1:2], +1 per word, wraps modulo MEM_SIZE/4.
//  Registered outputs: SL_CS_N=0 in every non-IDLE state.
//  U2F pop, one word per strobe:
//   - SL_AD=00, SL_OE_N=0 held.
//   - If SL_FLAGA=1: SL_RD_N=0 for exactly 1 cycle.
//   - Data sampled on SL_DT 2 cycles after the RD_N-low cycle (3 cycles/word).
//   - If SL_FLAGA=0, wait with RD_N=1, no timeout.
//  F2U push:
//   - SL_AD=11, SL_OE_N=1; one idle cycle after any SL_AD change before the first strobe.
//   - If SL_FLAGB=1: SL_WR_N=0 for 1 cycle with the word on SL_DT; FLAGB=0 stalls with WR_N=1.
//   - SL_DT driven only while SL_AD=11, else hi-Z.
//  FSM states:
//   - IDLE: SL_MODE==0 and FLAGA=1 -> GET_HDR.
//   - GET_HDR: -> GET_ADDR; header LEN=0 -> discard, IDLE.
//   - GET_ADDR: -> GET_DATA if write, else SEND_DATA.
//   - GET_DATA: each word written to mem; after LEN words -> SEND_STAT.
//   - SEND_STAT: pushes {16'h0,LEN} -> PKTEND.
//   - SEND_DATA: reads mem (sync read, 1-cycle latency, prefetch ahead of strobe); pushes LEN words -> PKTEND.
//   - PKTEND: SL_PKTEND_N=0 for 1 cycle with WR_N=1, SL_AD=11 -> IDLE.
//  Boundaries:
//   - FLAGA/FLAGB drop mid-packet: stall only, no data loss/duplication.
//   - SL_MODE change mid-packet: finish packet.
//   - Reset mid-packet: abort immediately, no partial PKTEND.
// TESTING
//  - Reset: SYS_RST=1 -> all strobes 1, SL_DT Z, SYS_RST_N=0; release -> SYS_RST_N=1 within 3 clks.
//  - PCLK_INV=1 -> SL_PCLK is inverse of SYS_CLK; PCLK_INV=0 -> in phase.
//  - Write then read back:
//    - write {1,LEN=4} @0x10 of 11,22,33,44 -> status word 0x4 then one PKTEND pulse;
//    - read {0,LEN=4} @0x10 -> 11,22,33,44 then PKTEND.
//  - Wrap: write LEN=2 at MEM_SIZE-4 -> words land at index last and 0; read back matches.
//  - Flow control: FLAGB low 10 cycles mid-read LEN=8 -> WR_N held 1, all 8 words delivered in order;
//    FLAGA gaps during write -> exact payload stored.
//  - LEN=0 header -> no memory write, no F2U traffic; SL_RST_N pulse mid-read aborts, next packet works.

Source files
------------

// File: rtl/fx3_mem_bridge.sv
// fx3_mem_bridge: FX3 slave-FIFO master that pops command packets, executes word-memory
// writes/reads and pushes status or read data back to the host.
module fx3_mem_bridge #(
    parameter logic        PCLK_INV    = 1'b1,
    parameter int          PCLK_FREQ   = 80_000_000,
    parameter logic [63:0] FPGA_FAMILY = "ARTIX7",
    parameter int          MEM_SIZE    = 8192
) (
    input  logic        SYS_CLK,
    input  logic        SYS_RST,
    input  logic        SYS_CLK_STABLE,
    output logic        SYS_RST_N,
    input  logic        SL_RST_N,
    output logic        SL_PCLK,
    output logic        SL_CS_N,
    output logic        SL_RD_N,
    output logic        SL_WR_N,
    output logic        SL_OE_N,
    output logic        SL_PKTEND_N,
    output logic [1:0]  SL_AD,
    input  logic        SL_FLAGA,
    input  logic        SL_FLAGB,
    input  logic        SL_FLAGC,
    input  logic        SL_FLAGD,
    inout  wire  [31:0] SL_DT,
    input  logic [1:0]  SL_MODE
);
    localparam int AW = $clog2(MEM_SIZE) - 2;
    localparam int WORDS = MEM_SIZE / 4;

    typedef enum logic [2:0] {IDLE, GET_HDR, GET_ADDR, GET_DATA, SEND_STAT, SEND_DATA, PKTEND} state_t;

    state_t st, ns;
    logic arst, rst;
    logic [1:0] sync;
    logic [1:0] ph;
    logic [15:0] len, cnt;
    logic wr_pkt, sample, push_go, pop_nx, pop_go;
    logic [AW-1:0] idx, idx_nx;
    logic [31:0] dout, mem_q;
    logic [31:0] mem [WORDS];
    logic unused_ok;

    assign unused_ok = ^{SL_FLAGC, SL_FLAGD, PCLK_FREQ, FPGA_FAMILY};
    assign SL_PCLK = PCLK_INV ? ~SYS_CLK : SYS_CLK;
    assign SL_DT = (SL_AD == 2'b11) ? dout : 32'hzzzz_zzzz;

    assign arst = SYS_RST | ~SL_RST_N | ~SYS_CLK_STABLE;
    always_ff @(posedge SYS_CLK or posedge arst) begin
        if (arst) sync <= 2'b00;
        else sync <= {sync[0], 1'b1};
    end
    assign rst = ~sync[1];
    assign SYS_RST_N = sync[1];

    // ph tracks a pop: 0 = RD_N low, 1/2 = latency, data captured at the end of 2, 3 = waiting
    always_comb begin
        ns = st;
        sample = (st == GET_HDR || st == GET_ADDR || st == GET_DATA) && ph == 2'd2;
        push_go = (st == SEND_STAT || st == SEND_DATA) && cnt != 16'd0 && SL_FLAGB;
        case (st)
            IDLE:      ns = (SL_MODE == 2'b00 && SL_FLAGA) ? GET_HDR : IDLE;
            GET_HDR:   ns = !sample ? GET_HDR : (SL_DT[15:0] == 16'd0) ? IDLE : GET_ADDR;
            GET_ADDR:  ns = !sample ? GET_ADDR : wr_pkt ? GET_DATA : SEND_DATA;
            GET_DATA:  ns = (sample && cnt == 16'd1) ? SEND_STAT : GET_DATA;
            SEND_STAT, SEND_DATA: ns = (cnt == 16'd0) ? PKTEND : st;
            default:   ns = IDLE;
        endcase
        pop_nx = ns == GET_HDR || ns == GET_ADDR || ns == GET_DATA;
        pop_go = pop_nx && SL_FLAGA && ph[1];
        idx_nx = (sample && st == GET_ADDR) ? SL_DT[AW+1:2] :
                 (push_go || (sample && st == GET_DATA)) ? idx + 1'b1 : idx;
    end

    always_ff @(posedge SYS_CLK or posedge rst) begin
        if (rst) begin
            st <= IDLE;
            ph <= 2'd3;
            SL_CS_N <= 1'b1;
            SL_RD_N <= 1'b1;
            SL_WR_N <= 1'b1;
            SL_OE_N <= 1'b1;
            SL_PKTEND_N <= 1'b1;
            SL_AD <= 2'b00;
            len <= 16'd0;
            cnt <= 16'd0;
            wr_pkt <= 1'b0;
            idx <= '0;
            dout <= 32'd0;
        end else begin
            st <= ns;
            ph <= pop_go ? 2'd0 : (ph == 2'd3) ? 2'd3 : ph + 2'd1;
            SL_CS_N <= ns == IDLE;
            SL_RD_N <= !pop_go;
            SL_WR_N <= !push_go;
            SL_OE_N <= !pop_nx;
            SL_PKTEND_N <= ns != PKTEND;
            SL_AD <= (ns == SEND_STAT || ns == SEND_DATA || ns == PKTEND) ? 2'b11 : 2'b00;
            idx <= idx_nx;
            if (sample && st == GET_HDR) begin
                wr_pkt <= SL_DT[31];
                len <= SL_DT[15:0];
            end
            if (sample && st == GET_ADDR) cnt <= len;
            // the final payload word leaves cnt at 1 so SEND_STAT pushes exactly one word
            if (sample && st == GET_DATA) cnt <= (cnt == 16'd1) ? 16'd1 : cnt - 16'd1;
            if (push_go) begin
                cnt <= cnt - 16'd1;
                dout <= (st == SEND_STAT) ? {16'h0, len} : mem_q;
            end
        end
    end

    // read address is the next index so mem_q always holds the word due at the next strobe
    always_ff @(posedge SYS_CLK) begin
        if (sample && st == GET_DATA) mem[idx] <= SL_DT;
        mem_q <= mem[idx_nx];
    end
endmodule

// File: tb/tb_fx3_mem_bridge.sv
// tb_fx3_mem_bridge: directed bench with an FX3 FIFO model for fx3_mem_bridge.
module tb_fx3_mem_bridge;
    logic clk = 1'b0;
    logic sys_rst = 1'b1;
    logic sl_rst_n = 1'b1;
    logic flagb = 1'b1;
    logic gate = 1'b1;
    logic [1:0] mode = 2'b00;
    wire [31:0] dt;
    logic [31:0] dt_drv = 32'h5A5A_A5A5;
    logic sys_rst_n, pclk, cs_n, rd_n, wr_n, oe_n, pktend_n;
    logic [1:0] ad;
    logic [31:0] u2f [256];
    logic [31:0] f2u [256];
    logic [31:0] expw [8];
    int wp = 0, rp = 0, fn = 0, pk = 0, prot_err = 0;
    int tests = 0, fails = 0;
    logic [1:0] prev_ad = 2'b00;
    wire flaga = gate && (rp != wp);
    wire pclk0;
    wire unused_rstn1, unused_cs1, unused_rd1, unused_wr1, unused_oe1, unused_pk1;
    wire [1:0] unused_ad1;
    wire [31:0] unused_dt1;

    always #5 clk = ~clk;

    assign dt = (ad == 2'b00) ? dt_drv : 32'hzzzz_zzzz;

    fx3_mem_bridge dut (
        .SYS_CLK(clk), .SYS_RST(sys_rst), .SYS_CLK_STABLE(1'b1), .SYS_RST_N(sys_rst_n),
        .SL_RST_N(sl_rst_n), .SL_PCLK(pclk), .SL_CS_N(cs_n), .SL_RD_N(rd_n), .SL_WR_N(wr_n),
        .SL_OE_N(oe_n), .SL_PKTEND_N(pktend_n), .SL_AD(ad), .SL_FLAGA(flaga), .SL_FLAGB(flagb),
        .SL_FLAGC(1'b0), .SL_FLAGD(1'b0), .SL_DT(dt), .SL_MODE(mode)
    );

    fx3_mem_bridge #(.PCLK_INV(1'b0)) u1 (
        .SYS_CLK(clk), .SYS_RST(1'b1), .SYS_CLK_STABLE(1'b1), .SYS_RST_N(unused_rstn1),
        .SL_RST_N(1'b1), .SL_PCLK(pclk0), .SL_CS_N(unused_cs1), .SL_RD_N(unused_rd1),
        .SL_WR_N(unused_wr1), .SL_OE_N(unused_oe1), .SL_PKTEND_N(unused_pk1), .SL_AD(unused_ad1),
        .SL_FLAGA(1'b0), .SL_FLAGB(1'b0), .SL_FLAGC(1'b0), .SL_FLAGD(1'b0), .SL_DT(unused_dt1),
        .SL_MODE(2'b00)
    );

    // FIFO model: serve U2F pops, capture F2U pushes, flag strobe-protocol violations
    always @(negedge clk) begin
        if (!rd_n) begin
            if (ad != 2'b00 || oe_n || cs_n) prot_err++;
            dt_drv = u2f[rp % 256];
            rp++;
        end
        if (!wr_n) begin
            if (ad != 2'b11 || prev_ad != 2'b11 || cs_n) prot_err++;
            f2u[fn % 256] = dt;
            fn++;
        end
        if (!pktend_n) begin
            if (!wr_n || ad != 2'b11) prot_err++;
            pk++;
        end
        prev_ad = ad;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        u2f[wp % 256] = w;
        wp++;
    endtask

    task automatic wait_pk(input int target, input string tag);
        int n = 0;
        while (pk < target && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk(tag, pk, target);
        repeat (4) @(negedge clk);
        chk({tag, "_single"}, pk, target);
    endtask

    task automatic xfer_write(input logic [31:0] addr, input int n, input string tag);
        int b = fn;
        int p = pk;
        push({1'b1, 15'd0, 16'(n)});
        push(addr);
        for (int i = 0; i < n; i++) push(expw[i]);
        wait_pk(p + 1, {tag, "_pkt"});
        chk({tag, "_nstat"}, fn - b, 1);
        chk({tag, "_stat"}, f2u[b % 256], n);
    endtask

    task automatic xfer_read(input logic [31:0] addr, input int n, input string tag);
        int b = fn;
        int p = pk;
        push({16'd0, 16'(n)});
        push(addr);
        wait_pk(p + 1, {tag, "_pkt"});
        chk({tag, "_nword"}, fn - b, n);
        for (int i = 0; i < n; i++) chk({tag, "_word"}, f2u[(b + i) % 256], expw[i]);
    endtask

    initial begin
        int b, p, n, viol, r0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_strobes", 32'({cs_n, rd_n, wr_n, oe_n, pktend_n}), 32'h1f);
        chk("rst_ad", 32'(ad), 32'd0);
        chk("rst_dt_released", dt, 32'h5A5A_A5A5);
        chk("rst_sys_rst_n", 32'(sys_rst_n), 32'd0);
        chk("pclk_inv_low", 32'(pclk), 32'd1);
        chk("pclk_noinv_low", 32'(pclk0), 32'd0);
        @(posedge clk);
        #1;
        chk("pclk_inv_high", 32'(pclk), 32'd0);
        chk("pclk_noinv_high", 32'(pclk0), 32'd1);
        @(negedge clk);
        sys_rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rstn_sync_1clk", 32'(sys_rst_n), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rstn_sync_3clk", 32'(sys_rst_n), 32'd1);
        @(negedge clk);

        expw[0] = 32'd11; expw[1] = 32'd22; expw[2] = 32'd33; expw[3] = 32'd44;
        xfer_write(32'h10, 4, "wr4");
        xfer_read(32'h10, 4, "rd4");

        // wrap: low address bits ignored, second word lands at index 0
        expw[0] = 32'hCAFE_0001; expw[1] = 32'hCAFE_0002;
        xfer_write(32'h1FFE, 2, "wrap_wr");
        xfer_read(32'h1FFC, 2, "wrap_rd");
        expw[0] = 32'hCAFE_0002;
        xfer_read(32'h0, 1, "wrap_idx0");

        for (int i = 0; i < 8; i++) expw[i] = 32'hA000_0000 + 32'(i * 7);
        xfer_write(32'h100, 8, "fc_wr");
        b = fn; p = pk;
        push(32'd8);
        push(32'h100);
        n = 0;
        while (fn < b + 2 && n < 300) begin @(negedge clk); n++; end
        chk("fc_started", 32'(fn >= b + 2), 32'd1);
        flagb = 1'b0;
        viol = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!wr_n) viol++;
        end
        chk("fc_stall_wr_n", viol, 0);
        flagb = 1'b1;
        wait_pk(p + 1, "fc_rd_pkt");
        chk("fc_rd_nword", fn - b, 8);
        for (int i = 0; i < 8; i++) chk("fc_rd_word", f2u[(b + i) % 256], expw[i]);

        for (int i = 0; i < 5; i++) expw[i] = 32'h5500_0000 | 32'(i * 3 + 1);
        b = fn; p = pk;
        push(32'h8000_0005);
        push(32'h200);
        for (int i = 0; i < 5; i++) push(expw[i]);
        for (int i = 0; i < 80; i++) begin
            gate = (i % 5) >= 2;
            @(negedge clk);
        end
        gate = 1'b1;
        wait_pk(p + 1, "gap_wr_pkt");
        chk("gap_wr_stat", f2u[b % 256], 32'd5);
        xfer_read(32'h200, 5, "gap_rd");

        b = fn; p = pk;
        push(32'h8000_0000);
        repeat (30) @(negedge clk);
        chk("len0_popped", rp, wp);
        chk("len0_no_f2u", fn, b);
        chk("len0_no_pkt", pk, p);
        chk("len0_idle", 32'(cs_n), 32'd1);
        expw[0] = 32'd11; expw[1] = 32'd22;
        xfer_read(32'h10, 2, "after_len0");

        mode = 2'b01;
        b = fn; p = pk; r0 = rp;
        push(32'd2);
        push(32'h10);
        repeat (20) @(negedge clk);
        chk("mode_hold_rp", rp, r0);
        chk("mode_hold_cs", 32'(cs_n), 32'd1);
        mode = 2'b00;
        n = 0;
        while (rp == r0 && n < 50) begin @(negedge clk); n++; end
        chk("mode_started", 32'(rp != r0), 32'd1);
        mode = 2'b10;
        wait_pk(p + 1, "mode_pkt");
        chk("mode_w0", f2u[b % 256], 32'd11);
        chk("mode_w1", f2u[(b + 1) % 256], 32'd22);
        mode = 2'b00;

        b = fn; p = pk;
        push(32'd8);
        push(32'h100);
        n = 0;
        while (fn < b + 3 && n < 300) begin @(negedge clk); n++; end
        flagb = 1'b0;
        @(negedge clk);
        sl_rst_n = 1'b0;
        #1;
        chk("abort_strobes", 32'({cs_n, rd_n, wr_n, oe_n, pktend_n}), 32'h1f);
        chk("abort_ad", 32'(ad), 32'd0);
        chk("abort_rst_n", 32'(sys_rst_n), 32'd0);
        repeat (2) @(negedge clk);
        sl_rst_n = 1'b1;
        flagb = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_no_pkt", pk, p);
        chk("abort_partial", 32'(fn - b < 8), 32'd1);
        chk("abort_recovered", 32'(sys_rst_n), 32'd1);
        expw[0] = 32'd11; expw[1] = 32'd22;
        xfer_read(32'h10, 2, "after_abort");

        chk("protocol", prot_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
